ffs_iter: RTL and testbench
===========================

# ffs_iter

Sequential, handshaked successor to the combinational find-first-set block. It accepts an `INPUT_WIDTH`-bit vector and emits the index of every set bit, one index per output beat. Order is highest index first or lowest index first, selected by `SIDE`. It sits between a request/bit-mask producer and any consumer that services set bits one at a time: scheduler, interrupt walker, free-list scanner.

## Interface
Parameters:
- `INPUT_WIDTH`, default 8: vector width. Values below 1 are clamped to 1, and a warning is printed at elaboration.
- `SIDE`, default 1'b0: enumeration order. 0 = highest set index first; 1 = lowest set index first.
- Derived `OUTPUT_WIDTH` = $clog2(max(INPUT_WIDTH,2)), not user-settable.

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer offers `in`.
- `in_ready`  out  1  block accepts `in` this cycle.
- `in`  in  INPUT_WIDTH  vector to enumerate.
- `out_valid`  out  1  `out`/`out_last`/`out_none` are valid.
- `out_ready`  in  1  consumer takes the current beat.
- `out`  out  OUTPUT_WIDTH  index of the current set bit.
- `out_last`  out  1  current beat is the final beat of its vector.
- `out_none`  out  1  the vector was all zeros; `out` = 0.

## Operation
- State: FSM {IDLE, BUSY}, plus residual register `res[INPUT_WIDTH-1:0]` and flag `none_r`.
- Reset: state = IDLE, `res` = 0, `none_r` = 0. Outputs `out_valid`=0, `out`=0, `out_last`=0, `out_none`=0.
- While `rst` is asserted, `in_ready`=0 and all inputs are ignored. Reset mid-vector discards the remaining indices; no partial beat is emitted after release.
- Accept = `in_valid & in_ready`. On accept: `res` <= `in`, `none_r` <= (`in` == 0), state <= BUSY.
- IDLE:
  - `in_ready`=1.
  - `out_valid`=0.
- BUSY:
  - `out_valid`=1.
  - `out` = highest set index of `res` (SIDE=0) or lowest (SIDE=1). If `none_r`, `out` = 0.
  - `out_last` = 1 when `res` with the selected bit cleared is zero, or when `none_r`.
  - `out_none` = `none_r`.
- Beat transfer = `out_valid & out_ready`.
  - On transfer with `out_last`=0: clear the selected bit of `res`.
  - On transfer with `out_last`=1: `in_ready` is also 1 in the same cycle (combinational path `out_ready`→`in_ready`). If `in_valid`, the new vector loads and state stays BUSY; otherwise state <= IDLE and `res` <= 0.
- `in_ready` = IDLE | (BUSY & `out_last` & `out_ready`), gated by `!rst`.
- Outputs never carry X. When `out_valid`=0, `out`, `out_last` and `out_none` are driven 0.
- Index arithmetic: `out` is an unsigned bit position 0..INPUT_WIDTH-1. Non-power-of-two widths never produce an index ≥ INPUT_WIDTH.
- INPUT_WIDTH=1: `out` is 1 bit and always 0. A set bit gives one beat with `out_last`=1; a zero gives one beat with `out_none`=1.

## Timing
- Latency: vector accepted at edge t gives first `out_valid` high in cycle t+1. All outputs except `in_ready` are registered or decoded from registers only.
- Throughput: k set bits give k beats (a zero vector gives 1 beat). Back-to-back vectors have no bubble when `in_valid` is high on the last beat's transfer cycle.
- Backpressure: while `out_valid & !out_ready`, `out`, `out_last` and `out_none` hold stable and `in_ready`=0.
- `in` is sampled only on the accept edge; later changes to `in` do not affect the vector in flight.
- Combinational depth: the priority encode over `res` is a single-cycle tree, log2(INPUT_WIDTH) levels of 2:1 selection.

## Test plan
- W=8, SIDE=0, `in`=8'b1010_0101, `out_ready`=1 → beats 7, 5, 2, 0 on cycles t+1..t+4; `out_last` high only with 0; `in_ready` high in cycle t+4.
- Same vector, SIDE=1 → beats 0, 2, 5, 7; `out_last` high only with 7.
- Zero vector, W=8 → exactly one beat with `out`=0, `out_none`=1, `out_last`=1. Then IDLE.
- Backpressure: `in`=8'h81, SIDE=0, `out_ready` low for 3 cycles → `out`=7 held stable for 4 cycles, `in_ready`=0. Then beats 7, 0.
- Back-to-back: W=5, vectors 5'b10000 then 5'b00011 with `in_valid` held → beats 4 (last), 1, 0 on consecutive cycles, no bubble; `out` width 3.
- Reset mid-vector: `in`=8'hFF, assert `rst` after 2 beats → `out_valid` drops to 0 asynchronously. After release the block is IDLE with `in_ready`=1, and no stale index appears.

Source files
------------

// File: rtl/ffs_iter_if.sv
// Handshake bundle for ffs_iter: a vector goes in on one side, set-bit indices
// come out on the other, one per beat.
interface ffs_iter_if #(
  parameter int INPUT_WIDTH = 8
);
  localparam int W            = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH;
  localparam int OUTPUT_WIDTH = $clog2((W < 2) ? 2 : W);

  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUTPUT_WIDTH-1:0] out;
  logic                    out_last;
  logic                    out_none;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_last, out_none
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_last, out_none
  );
endinterface

// File: rtl/ffs_iter.sv
// Iterative find-first-set: accepts a bit vector and emits the index of every
// set bit, one per output beat, highest first (SIDE=0) or lowest first (SIDE=1).
module ffs_iter #(
  parameter int INPUT_WIDTH = 8,
  parameter bit SIDE        = 1'b0
) (
  input logic      clk,
  input logic      rst,
  ffs_iter_if.slave bus
);
  localparam int W  = (INPUT_WIDTH < 1) ? 1 : INPUT_WIDTH;
  localparam int OW = $clog2((W < 2) ? 2 : W);

  generate
    if (INPUT_WIDTH < 1) begin : g_clamp_warn
      $warning("ffs_iter: INPUT_WIDTH below 1 clamped to 1");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  res;
  logic [W-1:0]  res_cleared;
  logic [W-1:0]  sel_mask;
  logic [OW-1:0] sel_idx;
  logic          none_r;
  logic          last_beat;
  logic          in_ready_w;
  logic          accept;
  logic          transfer;

  assign accept   = bus.in_valid & in_ready_w;
  assign transfer = (state_q == BUSY) & bus.out_ready;

  // Later matches overwrite earlier ones, so the scan direction picks the end.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    if (SIDE == 1'b0) begin
      for (int i = 0; i < W; i++) begin
        if (res[i]) begin
          sel_idx     = OW'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (res[i]) begin
          sel_idx     = OW'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
    res_cleared = res & ~sel_mask;
    last_beat   = none_r | (res_cleared == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        if (transfer && last_beat) state_d = accept ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ready path from out_ready lets a new vector load on the final beat.
  always_comb begin
    bus.out_valid = (state_q == BUSY);
    bus.out_last  = (state_q == BUSY) & last_beat;
    bus.out_none  = (state_q == BUSY) & none_r;
    bus.out       = ((state_q == BUSY) && !none_r) ? sel_idx : '0;
    in_ready_w    = !rst & ((state_q == IDLE) |
                            ((state_q == BUSY) & last_beat & bus.out_ready));
    bus.in_ready  = in_ready_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res    <= '0;
      none_r <= 1'b0;
    end else if (accept) begin
      res    <= bus.in;
      none_r <= (bus.in == '0);
    end else if (transfer) begin
      if (last_beat) begin
        res    <= '0;
        none_r <= 1'b0;
      end else begin
        res    <= res_cleared;
      end
    end
  end
endmodule

// File: tb/tb_ffs_iter.sv
// Directed bench for ffs_iter: two W=8 instances (both orders) run in lockstep,
// plus a W=5 instance for the back-to-back case.
module tb_ffs_iter;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] vec;
  logic       out_ready;
  logic       in_valid2;
  logic [4:0] vec2;
  logic       out_ready2;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  ffs_iter_if #(.INPUT_WIDTH(8)) bus0 ();
  ffs_iter_if #(.INPUT_WIDTH(8)) bus1 ();
  ffs_iter_if #(.INPUT_WIDTH(5)) bus2 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in        = vec;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in        = vec;
  assign bus1.out_ready = out_ready;
  assign bus2.in_valid  = in_valid2;
  assign bus2.in        = vec2;
  assign bus2.out_ready = out_ready2;

  ffs_iter #(.INPUT_WIDTH(8), .SIDE(1'b0)) u_hi (.clk(clk), .rst(rst), .bus(bus0));
  ffs_iter #(.INPUT_WIDTH(8), .SIDE(1'b1)) u_lo (.clk(clk), .rst(rst), .bus(bus1));
  ffs_iter #(.INPUT_WIDTH(5), .SIDE(1'b0)) u_w5 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [7:0]      v;
    int              n;
    logic [7:0][2:0] hi;
    logic [7:0][2:0] lo;
  } vec_t;

  vec_t tbl [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offers one vector on the shared W=8 input and steps past the accept edge.
  task automatic applyStimulus(input logic [7:0] v);
    checkOutput("pre hi in_ready", 32'(bus0.in_ready), 1);
    checkOutput("pre lo out_valid", 32'(bus1.out_valid), 0);
    in_valid = 1'b1;
    vec      = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vec      = ~v;
  endtask

  initial begin
    // Beat k of a vector lives in element [k]; the rightmost concat entry is [0].
    tbl[0] = '{8'hA5, 4, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd2,3'd5,3'd7}, {3'd0,3'd0,3'd0,3'd0,3'd7,3'd5,3'd2,3'd0}};
    tbl[1] = '{8'h00, 1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    tbl[2] = '{8'h81, 2, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd7}, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd7,3'd0}};
    tbl[3] = '{8'h10, 1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4}, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4}};
    tbl[4] = '{8'h0F, 4, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd2,3'd3}, {3'd0,3'd0,3'd0,3'd0,3'd3,3'd2,3'd1,3'd0}};
    tbl[5] = '{8'h80, 1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd7}, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd7}};
    tbl[6] = '{8'h01, 1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}};
    tbl[7] = '{8'h3C, 4, {3'd0,3'd0,3'd0,3'd0,3'd2,3'd3,3'd4,3'd5}, {3'd0,3'd0,3'd0,3'd0,3'd5,3'd4,3'd3,3'd2}};

    rst        = 1'b1;
    in_valid   = 1'b0;
    vec        = 8'h00;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    vec2       = 5'd0;
    out_ready2 = 1'b1;

    #12;
    checkOutput("rst in_ready", 32'(bus0.in_ready), 0);
    checkOutput("rst out_valid", 32'(bus0.out_valid), 0);
    checkOutput("rst out", 32'(bus0.out), 0);
    checkOutput("rst out_last", 32'(bus0.out_last), 0);
    checkOutput("rst out_none", 32'(bus0.out_none), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post rst in_ready", 32'(bus0.in_ready), 1);
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      applyStimulus(tbl[t].v);
      for (int b = 0; b < tbl[t].n; b++) begin
        checkOutput($sformatf("v%0d b%0d hi valid", t, b), 32'(bus0.out_valid), 1);
        checkOutput($sformatf("v%0d b%0d hi out", t, b), 32'(bus0.out), 32'(tbl[t].hi[b]));
        checkOutput($sformatf("v%0d b%0d lo out", t, b), 32'(bus1.out), 32'(tbl[t].lo[b]));
        checkOutput($sformatf("v%0d b%0d hi last", t, b), 32'(bus0.out_last), 32'(b == tbl[t].n - 1));
        checkOutput($sformatf("v%0d b%0d lo last", t, b), 32'(bus1.out_last), 32'(b == tbl[t].n - 1));
        checkOutput($sformatf("v%0d b%0d none", t, b), 32'(bus0.out_none), 32'(tbl[t].v == 8'h00));
        checkOutput($sformatf("v%0d b%0d in_ready", t, b), 32'(bus0.in_ready), 32'(b == tbl[t].n - 1));
        @(posedge clk); #1;
      end
      checkOutput($sformatf("v%0d idle hi valid", t), 32'(bus0.out_valid), 0);
      checkOutput($sformatf("v%0d idle lo valid", t), 32'(bus1.out_valid), 0);
      checkOutput($sformatf("v%0d idle out", t), 32'(bus0.out), 0);
    end

    // Backpressure: first beat must hold for four cycles with in_ready low.
    out_ready = 1'b0;
    applyStimulus(8'h81);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) out_ready = 1'b1;
      checkOutput($sformatf("bp c%0d hi out", c), 32'(bus0.out), 7);
      checkOutput($sformatf("bp c%0d lo out", c), 32'(bus1.out), 0);
      checkOutput($sformatf("bp c%0d valid", c), 32'(bus0.out_valid), 1);
      checkOutput($sformatf("bp c%0d last", c), 32'(bus0.out_last), 0);
      checkOutput($sformatf("bp c%0d in_ready", c), 32'(bus0.in_ready), 0);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    checkOutput("bp b1 hi out", 32'(bus0.out), 0);
    checkOutput("bp b1 lo out", 32'(bus1.out), 7);
    checkOutput("bp b1 last", 32'(bus0.out_last), 1);
    checkOutput("bp b1 in_ready", 32'(bus0.in_ready), 1);
    @(posedge clk); #1;
    checkOutput("bp idle", 32'(bus0.out_valid), 0);

    // Reset in the middle of a vector discards the remaining beats.
    applyStimulus(8'hFF);
    checkOutput("mid b0 out", 32'(bus0.out), 7);
    @(posedge clk); #1;
    checkOutput("mid b1 out", 32'(bus0.out), 6);
    @(posedge clk); #1;
    checkOutput("mid b2 out", 32'(bus0.out), 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid rst hi valid", 32'(bus0.out_valid), 0);
    checkOutput("mid rst lo valid", 32'(bus1.out_valid), 0);
    checkOutput("mid rst in_ready", 32'(bus0.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid rel in_ready", 32'(bus0.in_ready), 1);
    checkOutput("mid rel valid", 32'(bus0.out_valid), 0);
    @(posedge clk); #1;
    checkOutput("mid stale valid", 32'(bus0.out_valid), 0);
    checkOutput("mid stale out", 32'(bus0.out), 0);

    // Back-to-back on the W=5 instance: the second vector loads on the last beat.
    in_valid2 = 1'b1;
    vec2      = 5'b10000;
    @(posedge clk); #1;
    checkOutput("b2b b0 valid", 32'(bus2.out_valid), 1);
    checkOutput("b2b b0 out", 32'(bus2.out), 4);
    checkOutput("b2b b0 last", 32'(bus2.out_last), 1);
    checkOutput("b2b b0 in_ready", 32'(bus2.in_ready), 1);
    vec2 = 5'b00011;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    vec2      = 5'b11111;
    checkOutput("b2b b1 valid", 32'(bus2.out_valid), 1);
    checkOutput("b2b b1 out", 32'(bus2.out), 1);
    checkOutput("b2b b1 last", 32'(bus2.out_last), 0);
    @(posedge clk); #1;
    checkOutput("b2b b2 valid", 32'(bus2.out_valid), 1);
    checkOutput("b2b b2 out", 32'(bus2.out), 0);
    checkOutput("b2b b2 last", 32'(bus2.out_last), 1);
    @(posedge clk); #1;
    checkOutput("b2b idle", 32'(bus2.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
